// File: rtl/dds_pkg.sv
// dds_pkg: shared definitions for the dds_nco numerically controlled oscillator.
//   wave_e         - run-time waveform select encodings (2 bits)
//   NCO_LAT        - clocks from the issuing edge to out_valid
//   mid_val/peak_val - offset-binary mid-scale and sine peak for a sample width
package dds_pkg;

  typedef enum logic [1:0] {
    WAVE_SINE   = 2'd0,
    WAVE_SQUARE = 2'd1,
    WAVE_TRI    = 2'd2,
    WAVE_SAW    = 2'd3
  } wave_e;

  localparam int NCO_LAT = 3;

  function automatic int mid_val(int data_w);
    return 1 << (data_w - 1);
  endfunction

  function automatic int peak_val(int data_w);
    return (1 << (data_w - 1)) - 1;
  endfunction

endpackage

// File: rtl/dds_nco_if.sv
// dds_nco_if: control and sample bus of the NCO.
//   master: drives en/load/ftw_in/phase_offset/phase_clr/wave_sel, reads samples
//   slave : the NCO, drives wave_out/out_valid/sync
interface dds_nco_if #(
  parameter int PHASE_W = 16,
  parameter int DATA_W  = 8
);
  logic               en;
  logic               load;
  logic [PHASE_W-1:0] ftw_in;
  logic [PHASE_W-1:0] phase_offset;
  logic               phase_clr;
  logic [1:0]         wave_sel;
  logic [DATA_W-1:0]  wave_out;
  logic               out_valid;
  logic               sync;

  modport master (
    output en, load, ftw_in, phase_offset, phase_clr, wave_sel,
    input  wave_out, out_valid, sync
  );

  modport slave (
    input  en, load, ftw_in, phase_offset, phase_clr, wave_sel,
    output wave_out, out_valid, sync
  );
endinterface

// File: rtl/dds_quarter_rom.sv
// dds_quarter_rom: quarter-wave sine magnitude ROM, synchronous read.
//   clk  - system clock
//   addr - LUT_AW-bit table index
//   data - ROM_W-bit magnitude, one clock after addr
// Contents are round((2^ROM_W-1)*sin(i*pi/2^(LUT_AW+1))), computed at
// elaboration; ROM_FILE is kept for parameter compatibility.
module dds_quarter_rom #(
  parameter int    LUT_AW   = 6,
  parameter int    ROM_W    = 7,
  parameter string ROM_FILE = "sine.mem"
) (
  input  logic              clk,
  input  logic [LUT_AW-1:0] addr,
  output logic [ROM_W-1:0]  data
);
  logic [ROM_W-1:0] rom [2**LUT_AW];
  logic [ROM_W-1:0] data_d;
  logic [ROM_W-1:0] data_q;

  // Taylor series is accurate far beyond 1 LSB on [0, pi/2).
  function automatic logic [ROM_W-1:0] sine_entry(int unsigned i);
    real x;
    real term;
    real sum;
    x    = real'(i) * 3.14159265358979323846 / real'(2**(LUT_AW+1));
    sum  = x;
    term = x;
    for (int unsigned k = 1; k < 12; k++) begin
      term = -term * x * x / real'((2*k) * (2*k + 1));
      sum  = sum + term;
    end
    return ROM_W'($rtoi(sum * real'(2**ROM_W - 1) + 0.5));
  endfunction

  initial begin
    for (int unsigned i = 0; i < 2**LUT_AW; i++) rom[i] = sine_entry(i);
  end

  always_comb data_d = rom[addr];

  always_ff @(posedge clk) data_q <= data_d;

  assign data = data_q;
endmodule

// File: rtl/dds_nco.sv
// dds_nco: numerically controlled oscillator with programmable tuning word,
// phase offset and phase clear; sine/square/triangle/sawtooth output.
//   clk, rst - system clock, asynchronous active-high reset
//   bus      - dds_nco_if slave: en/load/ftw_in/phase_offset/phase_clr/wave_sel
//              in; wave_out/out_valid/sync out
// Pipeline: issue edge captures ROM address/quadrant and waveform bits (s1),
// next edge reads the ROM and forms square/tri/saw (s2), last edge registers
// the selected sample.
module dds_nco
  import dds_pkg::*;
#(
  parameter int    PHASE_W  = 16,
  parameter int    LUT_AW   = 6,
  parameter int    DATA_W   = 8,
  parameter string ROM_FILE = "sine.mem"
) (
  input  logic     clk,
  input  logic     rst,
  dds_nco_if.slave bus
);
  // Only the top TOP_W phase bits feed any waveform.
  localparam int TOP_W = (DATA_W + 1 > LUT_AW + 2) ? DATA_W + 1 : LUT_AW + 2;
  localparam logic [DATA_W-1:0] MID  = DATA_W'(mid_val(DATA_W));
  localparam logic [DATA_W-1:0] PEAK = DATA_W'(peak_val(DATA_W));

  logic [PHASE_W-1:0] acc_q, acc_d;
  logic [PHASE_W-1:0] ftw_q, ftw_d;
  logic [PHASE_W:0]   step_sum;
  logic [TOP_W-1:0]   ph_top;
  logic [LUT_AW-1:0]  idx;

  logic               s1_valid_q, s1_valid_d;
  logic               s1_sync_q, s1_sync_d;
  wave_e              s1_sel_q, s1_sel_d;
  logic               s1_neg_q, s1_neg_d;
  logic               s1_peak_q, s1_peak_d;
  logic [LUT_AW-1:0]  s1_addr_q, s1_addr_d;
  logic [DATA_W:0]    s1_u_q, s1_u_d;

  logic               s2_valid_q, s2_valid_d;
  logic               s2_sync_q, s2_sync_d;
  wave_e              s2_sel_q, s2_sel_d;
  logic               s2_neg_q, s2_neg_d;
  logic               s2_peak_q, s2_peak_d;
  logic [DATA_W-1:0]  s2_alt_q, s2_alt_d;

  logic [DATA_W-2:0]  rom_data;
  logic [DATA_W-1:0]  sine_mag;
  logic [DATA_W-1:0]  sine_val;

  logic [DATA_W-1:0]  wave_q, wave_d;
  logic               valid_q, valid_d;
  logic               sync_q, sync_d;

  dds_quarter_rom #(
    .LUT_AW   (LUT_AW),
    .ROM_W    (DATA_W - 1),
    .ROM_FILE (ROM_FILE)
  ) u_rom (
    .clk  (clk),
    .addr (s1_addr_q),
    .data (rom_data)
  );

  always_comb begin
    step_sum = {1'b0, acc_q} + {1'b0, ftw_q};
    ph_top   = TOP_W'((acc_q + bus.phase_offset) >> (PHASE_W - TOP_W));
    idx      = ph_top[TOP_W-3 -: LUT_AW];

    // phase_clr wins over the increment; the issued sample still uses acc_q.
    acc_d = acc_q;
    if (bus.en)        acc_d = step_sum[PHASE_W-1:0];
    if (bus.phase_clr) acc_d = '0;
    ftw_d = bus.load ? bus.ftw_in : ftw_q;

    s1_valid_d = bus.en;
    s1_sync_d  = step_sum[PHASE_W];
    s1_sel_d   = wave_e'(bus.wave_sel);
    s1_neg_d   = ph_top[TOP_W-1];
    // Odd quadrants mirror the table; index 0 there is the peak, which the
    // table does not hold.
    s1_peak_d  = ph_top[TOP_W-2] && (idx == '0);
    s1_addr_d  = ph_top[TOP_W-2] ? ('0 - idx) : idx;
    s1_u_d     = ph_top[TOP_W-1 -: DATA_W+1];

    s2_valid_d = s1_valid_q;
    s2_sync_d  = s1_sync_q;
    s2_sel_d   = s1_sel_q;
    s2_neg_d   = s1_neg_q;
    s2_peak_d  = s1_peak_q;
    unique case (s1_sel_q)
      WAVE_SQUARE: s2_alt_d = {DATA_W{~s1_u_q[DATA_W]}};
      WAVE_TRI:    s2_alt_d = s1_u_q[DATA_W] ? ~s1_u_q[DATA_W-1:0] : s1_u_q[DATA_W-1:0];
      default:     s2_alt_d = s1_u_q[DATA_W:1];
    endcase

    sine_mag = s2_peak_q ? PEAK : {1'b0, rom_data};
    sine_val = s2_neg_q ? (MID - sine_mag) : (MID + sine_mag);

    wave_d = wave_q;
    if (s2_valid_q) wave_d = (s2_sel_q == WAVE_SINE) ? sine_val : s2_alt_q;
    valid_d = s2_valid_q;
    sync_d  = s2_valid_q & s2_sync_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q      <= '0;
      ftw_q      <= '0;
      s1_valid_q <= 1'b0;
      s1_sync_q  <= 1'b0;
      s1_sel_q   <= WAVE_SINE;
      s1_neg_q   <= 1'b0;
      s1_peak_q  <= 1'b0;
      s1_addr_q  <= '0;
      s1_u_q     <= '0;
      s2_valid_q <= 1'b0;
      s2_sync_q  <= 1'b0;
      s2_sel_q   <= WAVE_SINE;
      s2_neg_q   <= 1'b0;
      s2_peak_q  <= 1'b0;
      s2_alt_q   <= '0;
      wave_q     <= MID;
      valid_q    <= 1'b0;
      sync_q     <= 1'b0;
    end else begin
      acc_q      <= acc_d;
      ftw_q      <= ftw_d;
      s1_valid_q <= s1_valid_d;
      s1_sync_q  <= s1_sync_d;
      s1_sel_q   <= s1_sel_d;
      s1_neg_q   <= s1_neg_d;
      s1_peak_q  <= s1_peak_d;
      s1_addr_q  <= s1_addr_d;
      s1_u_q     <= s1_u_d;
      s2_valid_q <= s2_valid_d;
      s2_sync_q  <= s2_sync_d;
      s2_sel_q   <= s2_sel_d;
      s2_neg_q   <= s2_neg_d;
      s2_peak_q  <= s2_peak_d;
      s2_alt_q   <= s2_alt_d;
      wave_q     <= wave_d;
      valid_q    <= valid_d;
      sync_q     <= sync_d;
    end
  end

  assign bus.wave_out  = wave_q;
  assign bus.out_valid = valid_q;
  assign bus.sync      = sync_q;
endmodule

// File: tb/tb_dds_nco.sv
// tb_dds_nco: table vectors, directed corner sequences and random stimulus
// against a phase-accumulator reference model with real-valued sine.
module tb_dds_nco;
  import dds_pkg::*;

  localparam real PI = 3.14159265358979323846;

  logic clk = 1'b0;
  logic rst = 1'b1;

  dds_nco_if #(.PHASE_W(16), .DATA_W(8)) bus ();

  dds_nco #(
    .PHASE_W  (16),
    .LUT_AW   (6),
    .DATA_W   (8),
    .ROM_FILE ("")
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  typedef struct {
    int unsigned due;
    int unsigned wave;
    int unsigned sync;
  } exp_t;

  exp_t        pend[$];
  int unsigned m_acc  = 0;
  int unsigned m_ftw  = 0;
  int unsigned m_last = 128;
  int unsigned cyc    = 0;

  task automatic check(string name, int unsigned act, int unsigned req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s cycle=%0d: got %0d, expected %0d", name, cyc, act, req);
    end
  endtask

  // Full-cycle sine sampled at 2^(LUT_AW+2) points, 127 amplitude around 128.
  function automatic int unsigned ref_sample(int unsigned q, int unsigned sel);
    real v;
    int unsigned mag;
    int unsigned u;
    case (sel)
      0: begin
        v   = 127.0 * $sin(2.0 * PI * real'(q >> 8) / 256.0);
        mag = $rtoi(((v < 0.0) ? -v : v) + 0.5);
        return (v < 0.0) ? 128 - mag : 128 + mag;
      end
      1: return (q < 32768) ? 255 : 0;
      2: begin
        u = q >> 7;
        return (u < 256) ? u : 511 - u;
      end
      default: return q >> 8;
    endcase
  endfunction

  task automatic model_edge();
    int unsigned p;
    cyc++;
    if (rst) return;
    if (bus.en) begin
      p = m_acc;
      pend.push_back('{cyc + 2, ref_sample((p + bus.phase_offset) & 16'hFFFF, bus.wave_sel),
                       ((p + m_ftw) > 65535) ? 1 : 0});
      m_acc = (p + m_ftw) & 16'hFFFF;
    end
    if (bus.phase_clr) m_acc = 0;
    if (bus.load) m_ftw = bus.ftw_in;
  endtask

  task automatic model_check();
    exp_t e;
    if (pend.size() > 0 && pend[0].due == cyc) begin
      e = pend.pop_front();
      check("out_valid", bus.out_valid, 1);
      check("wave_out", bus.wave_out, e.wave);
      check("sync", bus.sync, e.sync);
      m_last = e.wave;
    end else begin
      check("idle_valid", bus.out_valid, 0);
      check("idle_hold", bus.wave_out, m_last);
      check("idle_sync", bus.sync, 0);
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    model_check();
  endtask

  task automatic clear_inputs();
    bus.en = 0; bus.load = 0; bus.ftw_in = '0;
    bus.phase_offset = '0; bus.phase_clr = 0; bus.wave_sel = 2'd0;
  endtask

  typedef struct {
    int unsigned sel;
    int unsigned q;
    int unsigned exp;
  } vec_t;

  vec_t vecs[16];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    int unsigned n_valid;
    int unsigned sync_idx[$];
    int unsigned got[$];
    int unsigned p6_exp[5];

    vecs[0]  = '{0, 16'h0000, 128}; vecs[1]  = '{0, 16'h4000, 255};
    vecs[2]  = '{0, 16'h8000, 128}; vecs[3]  = '{0, 16'hC000, 1};
    vecs[4]  = '{0, 16'h1000, 177}; vecs[5]  = '{0, 16'h5000, 245};
    vecs[6]  = '{0, 16'hD000, 11};  vecs[7]  = '{2, 16'h0000, 0};
    vecs[8]  = '{2, 16'h4000, 128}; vecs[9]  = '{2, 16'h8000, 255};
    vecs[10] = '{2, 16'hC000, 127}; vecs[11] = '{1, 16'h0000, 255};
    vecs[12] = '{1, 16'h7FFF, 255}; vecs[13] = '{1, 16'h8000, 0};
    vecs[14] = '{3, 16'h8000, 128}; vecs[15] = '{3, 16'hFFFF, 255};
    p6_exp = '{0, 16, 32, 0, 3};

    clear_inputs();
    rst = 1;
    step();
    step();
    check("reset_wave", bus.wave_out, 128);
    check("reset_valid", bus.out_valid, 0);
    rst = 0;
    step();

    // ftw=1024 sine: latency, then sync on every 64th sample (P=64512).
    bus.load = 1; bus.ftw_in = 16'd1024;
    step();
    bus.load = 0; bus.en = 1;
    cnt = 0;
    do begin step(); cnt++; end while (!bus.out_valid && cnt < 8);
    check("first_latency", cnt, NCO_LAT);
    n_valid = 1;
    for (int i = 0; i < 140; i++) begin
      step();
      if (bus.out_valid) begin
        if (bus.sync) sync_idx.push_back(n_valid);
        n_valid++;
      end
    end
    check("sync_first_idx", (sync_idx.size() > 0) ? sync_idx[0] : 9999, 63);
    check("sync_second_idx", (sync_idx.size() > 1) ? sync_idx[1] : 9999, 127);

    // Asynchronous reset between edges with samples in flight.
    #2 rst = 1;
    #1;
    check("async_rst_wave", bus.wave_out, 128);
    check("async_rst_valid", bus.out_valid, 0);
    check("async_rst_sync", bus.sync, 0);
    pend.delete(); m_acc = 0; m_ftw = 0; m_last = 128;
    step();
    step();
    bus.en = 0;
    step();
    rst = 0;
    step();
    bus.en = 1;
    cnt = 0;
    do begin step(); cnt++; end while (!bus.out_valid && cnt < 8);
    check("post_rst_latency", cnt, NCO_LAT);
    bus.en = 0;
    repeat (3) step();

    // Single-sample vectors from a cleared accumulator, Q set by phase_offset.
    foreach (vecs[v]) begin
      bus.en = 0; bus.phase_clr = 1; bus.load = 1; bus.ftw_in = '0;
      step();
      bus.phase_clr = 0; bus.load = 0; bus.en = 1;
      bus.wave_sel = vecs[v].sel[1:0]; bus.phase_offset = vecs[v].q[15:0];
      step();
      bus.en = 0;
      step();
      step();
      check("vec_valid", bus.out_valid, 1);
      check($sformatf("vec%0d_wave", v), bus.wave_out, vecs[v].exp);
    end
    clear_inputs();

    // Square at ftw=4096, then switch to sawtooth mid-stream.
    bus.phase_clr = 1; bus.load = 1; bus.ftw_in = 16'd4096;
    step();
    bus.phase_clr = 0; bus.load = 0; bus.en = 1; bus.wave_sel = 2'd1;
    repeat (37) step();
    bus.wave_sel = 2'd3;
    repeat (20) step();

    // en gaps and triangle at ftw=256.
    bus.wave_sel = 2'd2; bus.load = 1; bus.ftw_in = 16'd256;
    step();
    bus.load = 0;
    for (int i = 0; i < 24; i++) begin
      bus.en = ((i % 8) < 5);
      step();
    end

    // load + phase_clr + en in one cycle: old P, then 0, then the new ftw.
    bus.en = 0; bus.phase_clr = 1; bus.load = 1; bus.ftw_in = 16'h1000;
    bus.wave_sel = 2'd3; bus.phase_offset = '0;
    repeat (4) step();
    bus.phase_clr = 0; bus.load = 0;
    for (int i = 0; i < 9; i++) begin
      bus.en        = (i < 5);
      bus.load      = (i == 2);
      bus.phase_clr = (i == 2);
      bus.ftw_in    = 16'h0300;
      step();
      if (bus.out_valid) got.push_back(bus.wave_out);
    end
    check("p6_count", got.size(), 5);
    for (int i = 0; i < 5; i++)
      check($sformatf("p6_sample%0d", i), (i < got.size()) ? got[i] : 999, p6_exp[i]);

    // Random mix of all controls.
    for (int i = 0; i < 600; i++) begin
      bus.en           = ($urandom_range(0, 3) != 0);
      bus.load         = ($urandom_range(0, 15) == 0);
      bus.ftw_in       = 16'($urandom);
      bus.phase_clr    = ($urandom_range(0, 31) == 0);
      bus.phase_offset = 16'($urandom);
      bus.wave_sel     = 2'($urandom_range(0, 3));
      step();
    end
    clear_inputs();
    repeat (4) step();
    check("drain_empty", pend.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
